// File: rtl/knap_enum.sv
// knap_enum: brute-force multi-constraint 0/1 knapsack search engine.
// Walks every item selection, one per clock, and keeps the highest-value
// selection that meets the minimum value, maximum weight and maximum volume
// limits. It also exports each candidate and its verdict so that an
// external selection checker can be run in lockstep with it.
// Optional feature macro: KNAP_EARLY_EXIT_EN. When it is defined, the search
// stops at the first valid candidate. When it is undefined, the search
// enumerates every selection.
module knap_enum #(
    parameter int N_ITEMS = 5,
    parameter int W       = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [W-1:0]           min_value,
    input  logic [W-1:0]           max_weight,
    input  logic [W-1:0]           max_volume,
    input  logic [N_ITEMS*W-1:0]   item_value,
    input  logic [N_ITEMS*W-1:0]   item_weight,
    input  logic [N_ITEMS*W-1:0]   item_volume,
    output logic                   busy,
    output logic                   done,
    output logic                   found,
    output logic [N_ITEMS-1:0]     best_sel,
    output logic [W-1:0]           best_value,
    output logic [N_ITEMS-1:0]     cand,
    output logic                   cand_valid
);

    typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

    state_t                 state_q, state_d;
    logic [W-1:0]           min_value_q, min_value_d;
    logic [W-1:0]           max_weight_q, max_weight_d;
    logic [W-1:0]           max_volume_q, max_volume_d;
    logic [N_ITEMS*W-1:0]   item_value_q, item_value_d;
    logic [N_ITEMS*W-1:0]   item_weight_q, item_weight_d;
    logic [N_ITEMS*W-1:0]   item_volume_q, item_volume_d;
    logic [N_ITEMS-1:0]     cand_q, cand_d;
    logic                   found_q, found_d;
    logic [N_ITEMS-1:0]     best_sel_q, best_sel_d;
    logic [W-1:0]           best_value_q, best_value_d;

    logic [W-1:0]           tot_value, tot_weight, tot_volume;
    logic                   cand_ok;
    logic                   last_cand;
    logic                   better;

    // Sum the latched item tables over the selected items. The sums wrap modulo 2^W.
    always_comb begin
        tot_value  = '0;
        tot_weight = '0;
        tot_volume = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (cand_q[i]) begin
                tot_value  = tot_value  + item_value_q[i*W +: W];
                tot_weight = tot_weight + item_weight_q[i*W +: W];
                tot_volume = tot_volume + item_volume_q[i*W +: W];
            end
        end
        cand_ok   = (tot_value >= min_value_q) && (tot_weight <= max_weight_q)
                    && (tot_volume <= max_volume_q);
        last_cand = &cand_q;
        better    = cand_ok && (!found_q || (tot_value > best_value_q));
    end

    // State and datapath registers; reset clears everything, including the latched tables.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            min_value_q   <= '0;
            max_weight_q  <= '0;
            max_volume_q  <= '0;
            item_value_q  <= '0;
            item_weight_q <= '0;
            item_volume_q <= '0;
            cand_q        <= '0;
            found_q       <= 1'b0;
            best_sel_q    <= '0;
            best_value_q  <= '0;
        end else begin
            state_q       <= state_d;
            min_value_q   <= min_value_d;
            max_weight_q  <= max_weight_d;
            max_volume_q  <= max_volume_d;
            item_value_q  <= item_value_d;
            item_weight_q <= item_weight_d;
            item_volume_q <= item_volume_d;
            cand_q        <= cand_d;
            found_q       <= found_d;
            best_sel_q    <= best_sel_d;
            best_value_q  <= best_value_d;
        end
    end

    // Next-state logic: leave EVAL after the last candidate, or at the first valid candidate in early-exit builds.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = EVAL;
            EVAL: begin
`ifdef KNAP_EARLY_EXIT_EN
                if (last_cand || cand_ok) state_d = DONE;
`else
                if (last_cand) state_d = DONE;
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath updates: latch the job on start, step the candidate, and keep the best strictly-greater result.
    always_comb begin
        min_value_d   = min_value_q;
        max_weight_d  = max_weight_q;
        max_volume_d  = max_volume_q;
        item_value_d  = item_value_q;
        item_weight_d = item_weight_q;
        item_volume_d = item_volume_q;
        cand_d        = cand_q;
        found_d       = found_q;
        best_sel_d    = best_sel_q;
        best_value_d  = best_value_q;
        if (state_q == IDLE && start) begin
            min_value_d   = min_value;
            max_weight_d  = max_weight;
            max_volume_d  = max_volume;
            item_value_d  = item_value;
            item_weight_d = item_weight;
            item_volume_d = item_volume;
            cand_d        = '0;
            found_d       = 1'b0;
            best_sel_d    = '0;
            best_value_d  = '0;
        end else if (state_q == EVAL) begin
            if (better) begin
                found_d      = 1'b1;
                best_sel_d   = cand_q;
                best_value_d = tot_value;
            end
            if (!last_cand) begin
                cand_d = cand_q + {{(N_ITEMS-1){1'b0}}, 1'b1};
            end
        end
    end

    // Output decode from the current state and the registered results.
    always_comb begin
        busy       = (state_q == EVAL);
        done       = (state_q == DONE);
        cand_valid = (state_q == EVAL) && cand_ok;
        found      = found_q;
        best_sel   = best_sel_q;
        best_value = best_value_q;
        cand       = cand_q;
    end

endmodule

// File: tb/tb_knap_enum.sv
// tb_knap_enum: self-checking bench for knap_enum. It runs directed searches
// against a behavioural knapsack model. A single compare process checks every
// cycle of each search.
module tb_knap_enum;

    localparam int N = 5;
    localparam int W = 32;
    localparam int NC = 1 << N;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   min_value, max_weight, max_volume;
    logic [N*W-1:0] item_value, item_weight, item_volume;
    logic           busy, done, found, cand_valid;
    logic [N-1:0]   best_sel, cand;
    logic [W-1:0]   best_value;

    knap_enum #(.N_ITEMS(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .min_value(min_value), .max_weight(max_weight), .max_volume(max_volume),
        .item_value(item_value), .item_weight(item_weight), .item_volume(item_volume),
        .busy(busy), .done(done), .found(found), .best_sel(best_sel),
        .best_value(best_value), .cand(cand), .cand_valid(cand_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nCompared = 0;
    int nMismatched = 0;

    // Model copy of the job
    logic [W-1:0] mVal[N], mWt[N], mVol[N];
    logic [W-1:0] mMinV, mMaxW, mMaxVol;

    // Model expectations for the current search
    bit           expFound;
    logic [N-1:0] expSel;
    logic [W-1:0] expValue;
    int           expLastEval;

    bit monActive = 0;
    bit monDone = 0;
    int monCycle = 0;

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] modelValue(int c);
        logic [W-1:0] s = '0;
        for (int i = 0; i < N; i++) if (((c >> i) & 1) != 0) s = s + mVal[i];
        return s;
    endfunction

    function automatic bit modelValid(int c);
        logic [W-1:0] tw = '0;
        logic [W-1:0] tl = '0;
        for (int i = 0; i < N; i++) begin
            if (((c >> i) & 1) != 0) begin
                tw = tw + mWt[i];
                tl = tl + mVol[i];
            end
        end
        return (modelValue(c) >= mMinV) && (tw <= mMaxW) && (tl <= mMaxVol);
    endfunction

    // Derive best selection and search length from the model rules
    task automatic computeExpected();
        expFound = 0;
        expSel = '0;
        expValue = '0;
        expLastEval = NC;
        for (int c = 0; c < NC; c++) begin
            if (modelValid(c)) begin
`ifdef KNAP_EARLY_EXIT_EN
                if (!expFound) begin
                    expFound = 1;
                    expSel = N'(c);
                    expValue = modelValue(c);
                    expLastEval = c + 1;
                end
`else
                if (!expFound || modelValue(c) > expValue) begin
                    expFound = 1;
                    expSel = N'(c);
                    expValue = modelValue(c);
                end
`endif
            end
        end
    endtask

    // Load a job into model and ports, then pulse start for one edge
    task automatic applyStimulus(input logic [W-1:0] v[N], input logic [W-1:0] wt[N],
                                 input logic [W-1:0] vl[N], input logic [W-1:0] minv,
                                 input logic [W-1:0] maxw, input logic [W-1:0] maxvol,
                                 input bit monitor);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            mVal[i] = v[i]; mWt[i] = wt[i]; mVol[i] = vl[i];
            item_value[i*W +: W] = v[i];
            item_weight[i*W +: W] = wt[i];
            item_volume[i*W +: W] = vl[i];
        end
        mMinV = minv; mMaxW = maxw; mMaxVol = maxvol;
        min_value = minv; max_weight = maxw; max_volume = maxvol;
        computeExpected();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        monCycle = 0;
        monDone = 0;
        monActive = monitor;
    endtask

    task automatic waitDone(input string name);
        for (int k = 0; k < 80 && !monDone; k++) @(posedge clk);
        nCompared++;
        if (!monDone) begin
            nMismatched++;
            $display("[TB] FAIL %s_timeout: got no completion expected completion", name);
            monActive = 0;
        end
    endtask

    // Per-cycle compare of DUT outputs against the model during and just after a search
    always @(negedge clk) begin
        if (monActive) begin
            monCycle++;
            if (monCycle <= expLastEval) begin
                checkOutput("busy", W'(busy), 1);
                checkOutput("done_early", W'(done), 0);
                checkOutput("cand", W'(cand), W'(monCycle - 1));
                checkOutput("cand_valid", W'(cand_valid), W'(modelValid(monCycle - 1)));
            end else if (monCycle == expLastEval + 1) begin
                checkOutput("done", W'(done), 1);
                checkOutput("busy_at_done", W'(busy), 0);
                checkOutput("cand_valid_at_done", W'(cand_valid), 0);
                checkOutput("found", W'(found), W'(expFound));
                checkOutput("best_sel", W'(best_sel), W'(expSel));
                checkOutput("best_value", best_value, expValue);
            end else begin
                checkOutput("done_one_cycle", W'(done), 0);
                checkOutput("found_hold", W'(found), W'(expFound));
                checkOutput("best_value_hold", best_value, expValue);
                monActive = 0;
                monDone = 1;
            end
        end
    end

    logic [W-1:0] dV[N], dW[N], dL[N], tV[N], tW[N], tL[N];
    int doneCount;

    initial begin
        dV = '{4, 2, 2, 1, 10};
        dW = '{12, 1, 2, 1, 4};
        dL = '{1, 1, 1, 1, 1};
        tV = '{5, 5, 0, 0, 0};
        tW = '{1, 1, 1, 1, 1};
        tL = '{0, 0, 0, 0, 0};
        start = 0;
        min_value = '0; max_weight = '0; max_volume = '0;
        item_value = '0; item_weight = '0; item_volume = '0;
        rst_n = 0;
        #2;
        checkOutput("rst_busy", W'(busy), 0);
        checkOutput("rst_done", W'(done), 0);
        checkOutput("rst_found", W'(found), 0);
        checkOutput("rst_best_sel", W'(best_sel), 0);
        checkOutput("rst_best_value", best_value, 0);
        checkOutput("rst_cand", W'(cand), 0);
        @(negedge clk);
        rst_n = 1;

        $display("[TB] scenario 1: main search");
        applyStimulus(dV, dW, dL, 15, 16, 5, 1);
        waitDone("s1");
        checkOutput("s1_lit_found", W'(found), 1);
        checkOutput("s1_lit_best_sel", W'(best_sel), 32'b11110);
        checkOutput("s1_lit_best_value", best_value, 15);

        $display("[TB] scenario 2: nothing valid");
        applyStimulus(dV, dW, dL, 100, 16, 5, 1);
        waitDone("s2");
        checkOutput("s2_lit_found", W'(found), 0);
        checkOutput("s2_lit_best_sel", W'(best_sel), 0);
        checkOutput("s2_lit_best_value", best_value, 0);

        $display("[TB] scenario 3: value tie");
        applyStimulus(tV, tW, tL, 5, 1, 5, 1);
        waitDone("s3");
        checkOutput("s3_lit_best_sel", W'(best_sel), 32'b00001);
        checkOutput("s3_lit_best_value", best_value, 5);

        $display("[TB] scenario 4a: reset mid-search");
        applyStimulus(dV, dW, dL, 15, 16, 5, 0);
        repeat (9) @(posedge clk);
        #1 rst_n = 0;
        #1;
        checkOutput("s4_rst_busy", W'(busy), 0);
        checkOutput("s4_rst_done", W'(done), 0);
        checkOutput("s4_rst_found", W'(found), 0);
        checkOutput("s4_rst_best_sel", W'(best_sel), 0);
        checkOutput("s4_rst_best_value", best_value, 0);
        checkOutput("s4_rst_cand", W'(cand), 0);
        checkOutput("s4_rst_cand_valid", W'(cand_valid), 0);
        @(negedge clk);
        rst_n = 1;
        doneCount = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) doneCount++;
            if (k == 39) checkOutput("s4_idle_busy", W'(busy), 0);
        end
        checkOutput("s4_no_done", W'(doneCount), 0);

        $display("[TB] scenario 4b: start and data changes during search");
        applyStimulus(dV, dW, dL, 15, 16, 5, 1);
        repeat (5) @(posedge clk);
        #1 start = 1;
        min_value = 0;
        max_weight = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 start = 0;
        waitDone("s4b");
        checkOutput("s4b_lit_best_sel", W'(best_sel), 32'b11110);

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/knap_enum.md
Name: knap_enum

Overview:
- Sequential brute-force search engine for the multi-constraint 0/1 knapsack flow.
- Enumerates every item selection, one per clock, and reports the best selection. The best selection is the one with maximum value that meets three limits: minimum value, maximum weight and maximum volume.
- Acts as the producer/driver side of the selection-validity checker.
  - Exports each candidate vector and its verdict, so the standalone checker can be compared against it in lockstep.

Parameters:
- N_ITEMS, 5, number of items; candidate and selection vectors are N_ITEMS bits wide. Bit i is item i (A=bit0 … E=bit4).
- W, 32, width of every value/weight/volume quantity, limit and total.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a search; honoured only in IDLE
- min_value  in  W  minimum acceptable total value
- max_weight  in  W  maximum total weight
- max_volume  in  W  maximum total volume
- item_value  in  N_ITEMS*W  packed per-item values; item i at bits [i*W +: W]
- item_weight  in  N_ITEMS*W  packed per-item weights
- item_volume  in  N_ITEMS*W  packed per-item volumes
- busy  out  1  high in EVAL
- done  out  1  one-cycle pulse at end of search
- found  out  1  at least one valid candidate seen
- best_sel  out  N_ITEMS  best valid selection
- best_value  out  W  total value of best_sel
- cand  out  N_ITEMS  candidate under evaluation this cycle
- cand_valid  out  1  verdict for cand this cycle; qualified by busy

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE.
  - busy, done, found, cand_valid = 0; best_sel = 0; best_value = 0; cand = 0.
  - Internal latched limits and tables are cleared to 0.
- FSM states: IDLE, EVAL, DONE.
- IDLE:
  - If start=1, latch all limits and item tables, clear found, best_sel and best_value, set cand=0, and go to EVAL.
  - Otherwise hold all outputs.
- EVAL:
  - Each cycle, compute combinationally from the latched data:
    - totals = sum over set bits of cand, computed modulo 2^W (wrap, no saturation);
    - cand_valid = (tv >= min_value) && (tw <= max_weight) && (tvol <= max_volume), all comparisons unsigned.
  - Best update at the clock edge: if cand_valid and (!found || tv > best_value), load best_sel=cand and best_value=tv, and set found=1.
    - The comparison is strict, so on a value tie the lowest-numbered candidate is kept.
  - If cand == 2^N_ITEMS-1, go to DONE. Otherwise cand increments.
  - cand_valid = 0 outside EVAL.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Latency:
  - start sampled at edge 0.
  - EVAL occupies 2^N_ITEMS cycles.
  - done is high in cycle 2^N_ITEMS+1 after the start edge (33 cycles for N_ITEMS=5).
- found, best_sel and best_value hold after done until the next accepted start.
- If found=0 at done, best_sel=0 and best_value=0.
- start while busy or in DONE is ignored; changes to the data inputs after start do not affect the running search.
- Reset asserted mid-EVAL aborts immediately to the reset state; no done pulse is produced.
- start asserted in the same cycle that DONE returns to IDLE is not accepted; start is sampled only while in IDLE.

Optional Feature:
- Macro: KNAP_EARLY_EXIT_EN.
- Defined: the first candidate with cand_valid=1 is recorded as best and the FSM goes directly from EVAL to DONE after that cycle. The result is the lowest-index valid selection, not the maximum-value one.
- Undefined: the full enumeration described above.

Test Plan:
- Item data used in scenarios 1, 2 and 5:
  - values 4,2,2,1,10; weights 12,1,2,1,4; volumes 1,1,1,1,1.
  - Limits: min_value 15, max_weight 16, max_volume 5.
- 1. Pulse start with the item data -> done at cycle 33, found=1, best_sel=5'b11110, best_value=15. Every cycle's cand_valid matches an independent checker model.
- 2. Same data with min_value=100 -> done at cycle 33, found=0, best_sel=0, best_value=0; cand_valid never asserted.
- 3. Tie case:
  - Setup: values 5,5,0,0,0; weights 1,1,1,1,1; volumes 0; min_value 5, max_weight 1, max_volume 5.
  - Result: best_sel=5'b00001, best_value=5. The lowest-index candidate wins the tie.
- 4. Reset and ignored start:
  - Drop rst_n at cycle 10 of EVAL -> all outputs 0, state IDLE, no done pulse.
  - A start pulsed during EVAL -> ignored; done still occurs exactly 33 cycles after the original start.
- 5. With KNAP_EARLY_EXIT_EN and the item data -> search stops after cand=5'b11110 is evaluated. done asserts the cycle after that evaluation, with found=1, best_sel=5'b11110, best_value=15.
